muldiv_ctrl: RTL



---
 rtl/muldiv_ctrl_if.sv | 25 ++
 rtl/muldiv_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between the main control unit (master) and the
// mult/div sequencer (slave).
interface muldiv_ctrl_if;
    logic        start;
    logic        op;
    logic [31:0] b_operand;
    logic        mult_ctrl;
    logic        div_ctrl;
    logic        hi_src;
    logic        lo_src;
    logic        hilo_write;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start, op, b_operand,
        input  mult_ctrl, div_ctrl, hi_src, lo_src, hilo_write, busy, done, div_zero
    );

    modport slave (
        input  start, op, b_operand,
        output mult_ctrl, div_ctrl, hi_src, lo_src, hilo_write, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multicycle mult/div units: start pulse, latency count, HI/LO commit.
// Define MULDIV_DIVZERO_CHECK_EN to trap a zero divisor at acceptance (ERR state).
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_ctrl_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) > 6) ? $clog2(MAX_CYCLES) : 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op_q;
    logic             r_mult_ctrl;
    logic             r_div_ctrl;
    logic             r_hilo_write;
    logic             r_done;
    logic [CNT_W-1:0] w_cnt_load;

    assign w_cnt_load = bus.op ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

`ifdef MULDIV_DIVZERO_CHECK_EN
    logic r_div_zero;
    logic w_div_by_zero;
    assign w_div_by_zero = bus.op && (bus.b_operand == '0);
`else
    // Divisor only matters to the zero check; keep it referenced without logic.
    logic w_unused_b_operand;
    assign w_unused_b_operand = ^bus.b_operand;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_op_q       <= 1'b0;
            r_mult_ctrl  <= 1'b0;
            r_div_ctrl   <= 1'b0;
            r_hilo_write <= 1'b0;
            r_done       <= 1'b0;
`ifdef MULDIV_DIVZERO_CHECK_EN
            r_div_zero   <= 1'b0;
`endif
        end else begin
            // All pulse outputs are single-cycle unless re-asserted below.
            r_mult_ctrl  <= 1'b0;
            r_div_ctrl   <= 1'b0;
            r_hilo_write <= 1'b0;
            r_done       <= 1'b0;
`ifdef MULDIV_DIVZERO_CHECK_EN
            r_div_zero   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op_q <= bus.op;
`ifdef MULDIV_DIVZERO_CHECK_EN
                        if (w_div_by_zero) begin
                            r_state    <= ERR;
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state     <= RUN;
                            r_cnt       <= w_cnt_load;
                            r_mult_ctrl <= ~bus.op;
                            r_div_ctrl  <= bus.op;
                        end
`else
                        r_state     <= RUN;
                        r_cnt       <= w_cnt_load;
                        r_mult_ctrl <= ~bus.op;
                        r_div_ctrl  <= bus.op;
`endif
                    end
                end
                RUN: begin
                    if (r_cnt == '0) begin
                        r_state      <= WB;
                        r_hilo_write <= 1'b1;
                        r_done       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                WB: r_state <= IDLE;
`ifdef MULDIV_DIVZERO_CHECK_EN
                ERR: r_state <= IDLE;
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mult_ctrl  = r_mult_ctrl;
    assign bus.div_ctrl   = r_div_ctrl;
    assign bus.hi_src     = r_op_q;
    assign bus.lo_src     = r_op_q;
    assign bus.hilo_write = r_hilo_write;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
`ifdef MULDIV_DIVZERO_CHECK_EN
    assign bus.div_zero   = r_div_zero;
`else
    assign bus.div_zero   = 1'b0;
`endif
endmodule
